// File: rtl/push_crc_pkg.sv
// Shared FSM encoding and default CRC-8 constants for the push/CRC engine.
package push_crc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PUSH_A = 2'd1,
      PUSH_B = 2'd2,
      CRC    = 2'd3
   } state_t;

   localparam int         DATA_W_DEF     = 8;
   localparam logic [7:0] CRC_POLY_DEF   = 8'h07;
   localparam logic [7:0] CRC_INIT_DEF   = 8'h00;
   localparam logic [7:0] CRC_XOROUT_DEF = 8'h00;

endpackage

// File: rtl/crc8_step.sv
// Folds one DATA_W-bit word into a CRC-8 in a single combinational step, MSB first.
module crc8_step
   import push_crc_pkg::*;
#(
   parameter int         DATA_W   = DATA_W_DEF,
   parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
   input  logic [7:0]        crc_in,
   input  logic [DATA_W-1:0] data,
   output logic [7:0]        crc_nxt
);

   logic [7:0] crc_acc;

   always_comb begin
      crc_acc = crc_in;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         if (crc_acc[7] ^ data[i]) begin
            crc_acc = {crc_acc[6:0], 1'b0} ^ CRC_POLY;
         end else begin
            crc_acc = {crc_acc[6:0], 1'b0};
         end
      end
      crc_nxt = crc_acc;
   end

endmodule

// File: rtl/push_crc_engine.sv
// Captures a two-word record, streams word A then word B over valid/ready,
// and reports the CRC-8 of both words with a one-cycle crc_valid pulse.
module push_crc_engine
   import push_crc_pkg::*;
#(
   parameter int         DATA_W     = DATA_W_DEF,
   parameter logic [7:0] CRC_POLY   = CRC_POLY_DEF,
   parameter logic [7:0] CRC_INIT   = CRC_INIT_DEF,
   parameter logic [7:0] CRC_XOROUT = CRC_XOROUT_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              new_data,
   input  logic [DATA_W-1:0] data_a,
   input  logic [DATA_W-1:0] data_b,
   input  logic              flush,
   output logic              in_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   input  logic              m_ready,
   output logic              push_a_done,
   output logic              push_b_done,
   output logic              crc_valid,
   output logic [7:0]        crc_out
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [7:0]        crc_q, crc_d;
   logic [7:0]        crc_step;
   logic              push_a_done_q, push_a_done_d;
   logic              push_b_done_q, push_b_done_d;
   logic              crc_valid_q, crc_valid_d;
   logic [7:0]        crc_out_q, crc_out_d;

   // Stream outputs decode straight from the state register, so m_ready never reaches m_valid.
   assign in_ready    = (state_q == IDLE);
   assign m_valid     = (state_q == PUSH_A) || (state_q == PUSH_B);
   assign m_data      = (state_q == PUSH_A) ? a_q :
                        (state_q == PUSH_B) ? b_q : '0;
   assign push_a_done = push_a_done_q;
   assign push_b_done = push_b_done_q;
   assign crc_valid   = crc_valid_q;
   assign crc_out     = crc_out_q;

   crc8_step #(
      .DATA_W   (DATA_W),
      .CRC_POLY (CRC_POLY)
   ) u_crc8_step (
      .crc_in  (crc_q),
      .data    (m_data),
      .crc_nxt (crc_step)
   );

   always_comb begin
      // NOTE: every variable gets its hold/idle value first so no path infers a latch.
      state_d       = state_q;
      a_d           = a_q;
      b_d           = b_q;
      crc_d         = crc_q;
      push_a_done_d = 1'b0;
      push_b_done_d = 1'b0;
      crc_valid_d   = 1'b0;
      crc_out_d     = crc_out_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (new_data) begin
                  a_d     = data_a;
                  b_d     = data_b;
                  crc_d   = CRC_INIT;
                  state_d = PUSH_A;
               end
            end
            PUSH_A: begin
               if (m_ready) begin
                  crc_d         = crc_step;
                  push_a_done_d = 1'b1;
                  state_d       = PUSH_B;
               end
            end
            PUSH_B: begin
               if (m_ready) begin
                  crc_d         = crc_step;
                  push_b_done_d = 1'b1;
                  state_d       = CRC;
               end
            end
            CRC: begin
               crc_out_d   = crc_q ^ CRC_XOROUT;
               crc_valid_d = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= IDLE;
         a_q           <= '0;
         b_q           <= '0;
         crc_q         <= '0;
         push_a_done_q <= 1'b0;
         push_b_done_q <= 1'b0;
         crc_valid_q   <= 1'b0;
         crc_out_q     <= '0;
      end else begin
         state_q       <= state_d;
         a_q           <= a_d;
         b_q           <= b_d;
         crc_q         <= crc_d;
         push_a_done_q <= push_a_done_d;
         push_b_done_q <= push_b_done_d;
         crc_valid_q   <= crc_valid_d;
         crc_out_q     <= crc_out_d;
      end
   end

endmodule

// File: tb/tb_push_crc_engine.sv
// Self-checking bench for push_crc_engine: scoreboard of stream words and CRCs,
// negedge monitor for handshakes and pulses, one task per scenario.
module tb_push_crc_engine;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       new_data = 1'b0;
   logic [7:0] data_a = '0;
   logic [7:0] data_b = '0;
   logic       flush = 1'b0;
   logic       m_ready = 1'b0;
   logic       in_ready, m_valid, push_a_done, push_b_done, crc_valid;
   logic [7:0] m_data, crc_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_words[$];
   logic [7:0] exp_crc[$];
   logic [7:0] last_crc = 8'h00;

   always #5 clk = ~clk;

   push_crc_engine dut (
      .clk         (clk),
      .rstn        (rstn),
      .new_data    (new_data),
      .data_a      (data_a),
      .data_b      (data_b),
      .flush       (flush),
      .in_ready    (in_ready),
      .m_valid     (m_valid),
      .m_data      (m_data),
      .m_ready     (m_ready),
      .push_a_done (push_a_done),
      .push_b_done (push_b_done),
      .crc_valid   (crc_valid),
      .crc_out     (crc_out)
   );

   function automatic logic [7:0] model_crc(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] c;
      logic [7:0] w;
      logic       fb;
      c = 8'h00;
      for (int k = 0; k < 2; k++) begin
         w = (k == 0) ? a : b;
         for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ w[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return c;
   endfunction

   // ---------------- monitor / scoreboard consumer ----------------
   logic       mon_phase_b = 1'b0;
   logic       mon_exp_a = 1'b0;
   logic       mon_exp_b = 1'b0;
   logic       mon_prev_stall = 1'b0;
   logic [7:0] mon_prev_data = '0;
   logic       mon_prev_crcv = 1'b0;
   logic [7:0] mon_w;
   logic       mon_hs;
   int         seen_a = 0, seen_b = 0, seen_c = 0;

   always @(negedge clk) begin
      if (!rstn) begin
         mon_phase_b    = 1'b0;
         mon_exp_a      = 1'b0;
         mon_exp_b      = 1'b0;
         mon_prev_stall = 1'b0;
         mon_prev_crcv  = 1'b0;
      end else begin
         n_tests++;
         if (push_a_done !== mon_exp_a || push_b_done !== mon_exp_b) begin
            n_fail++;
            $display("FAIL done_pulses: got a=%b b=%b expected a=%b b=%b at %0t",
                     push_a_done, push_b_done, mon_exp_a, mon_exp_b, $time);
         end
         if (push_a_done === 1'b1) seen_a++;
         if (push_b_done === 1'b1) seen_b++;
         if (mon_prev_stall) begin
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== mon_prev_data) begin
               n_fail++;
               $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h at %0t",
                        m_valid, m_data, mon_prev_data, $time);
            end
         end
         if (crc_valid === 1'b1) begin
            seen_c++;
            n_tests++;
            if (mon_prev_crcv) begin
               n_fail++;
               $display("FAIL crc_valid_double: crc_valid high two cycles in a row at %0t", $time);
            end else if (exp_crc.size() == 0) begin
               n_fail++;
               $display("FAIL crc_unexpected: got crc_out=%h with none expected at %0t", crc_out, $time);
            end else begin
               mon_w = exp_crc.pop_front();
               if (crc_out !== mon_w) begin
                  n_fail++;
                  $display("FAIL crc_value: got %h expected %h at %0t", crc_out, mon_w, $time);
               end
            end
         end
         mon_hs = (m_valid === 1'b1) && (m_ready === 1'b1);
         if (mon_hs) begin
            n_tests++;
            if (exp_words.size() == 0) begin
               n_fail++;
               $display("FAIL word_unexpected: got m_data=%h with none expected at %0t", m_data, $time);
            end else begin
               mon_w = exp_words.pop_front();
               if (m_data !== mon_w) begin
                  n_fail++;
                  $display("FAIL word_value: got %h expected %h at %0t", m_data, mon_w, $time);
               end
            end
         end
         mon_exp_a      = mon_hs && !flush && !mon_phase_b;
         mon_exp_b      = mon_hs && !flush && mon_phase_b;
         if (flush) mon_phase_b = 1'b0;
         else if (mon_hs) mon_phase_b = ~mon_phase_b;
         mon_prev_stall = (m_valid === 1'b1) && !m_ready && !flush;
         mon_prev_data  = m_data;
         mon_prev_crcv  = (crc_valid === 1'b1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [7:0] a, input logic [7:0] b, input bit want_crc);
      @(posedge clk); #1;
      new_data = 1'b1;
      data_a   = a;
      data_b   = b;
      exp_words.push_back(a);
      exp_words.push_back(b);
      if (want_crc) begin
         exp_crc.push_back(model_crc(a, b));
         last_crc = model_crc(a, b);
      end
      @(posedge clk); #1;
      new_data = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || m_valid !== 1'b0 || push_a_done !== 1'b0 || push_b_done !== 1'b0 ||
          crc_valid !== 1'b0 || crc_out !== 8'h00 || m_data !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: got rdy=%b v=%b d=%h pa=%b pb=%b cv=%b crc=%h expected 1 0 00 0 0 0 00",
                  in_ready, m_valid, m_data, push_a_done, push_b_done, crc_valid, crc_out);
      end
      @(posedge clk); #1;
      rstn    = 1'b1;
      m_ready = 1'b1;
      send(8'hA5, 8'h5A, 1'b1);
      @(posedge clk); #1;
      m_ready = 1'b0;
      @(posedge clk); #3;
      rstn = 1'b0;
      #1;
      n_tests++;
      if (m_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_async: got m_valid=%b in_ready=%b expected 0 1", m_valid, in_ready);
      end
      repeat (2) @(negedge clk);
      exp_words.delete();
      exp_crc.delete();
      last_crc = 8'h00;
      @(posedge clk); #1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_tests++;
         if (in_ready !== 1'b1 || m_valid !== 1'b0 || push_a_done !== 1'b0 ||
             push_b_done !== 1'b0 || crc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b v=%b pa=%b pb=%b cv=%b expected 1 0 0 0 0",
                     in_ready, m_valid, push_a_done, push_b_done, crc_valid);
         end
      end
   endtask

   task automatic test_basic();
      int sa, sb, sc;
      m_ready = 1'b1;
      sa = seen_a; sb = seen_b; sc = seen_c;
      send(8'h01, 8'h00, 1'b1);
      @(negedge clk);
      n_tests++;
      if (m_valid !== 1'b1 || m_data !== 8'h01) begin
         n_fail++;
         $display("FAIL basic_first: got valid=%b data=%h expected 1 01", m_valid, m_data);
      end
      for (int i = 0; i < 50 && (exp_words.size() != 0 || exp_crc.size() != 0); i++) @(negedge clk);
      n_tests++;
      if (exp_words.size() != 0 || exp_crc.size() != 0) begin
         n_fail++;
         $display("FAIL basic_drain: got %0d words %0d crcs pending expected 0 0", exp_words.size(), exp_crc.size());
      end
      n_tests++;
      if (crc_out !== 8'h15) begin
         n_fail++;
         $display("FAIL basic_crc: got %h expected 15", crc_out);
      end
      n_tests++;
      if (seen_a - sa != 1 || seen_b - sb != 1 || seen_c - sc != 1) begin
         n_fail++;
         $display("FAIL basic_pulses: got a=%0d b=%0d crc=%0d expected 1 1 1", seen_a - sa, seen_b - sb, seen_c - sc);
      end
   endtask

   task automatic test_stall();
      m_ready = 1'b0;
      send(8'h00, 8'h01, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (m_valid !== 1'b1 || m_data !== 8'h00) begin
            n_fail++;
            $display("FAIL stall_a%0d: got valid=%b data=%h expected 1 00", i, m_valid, m_data);
         end
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      for (int i = 0; i < 50 && (exp_words.size() != 0 || exp_crc.size() != 0); i++) @(negedge clk);
      n_tests++;
      if (exp_words.size() != 0 || exp_crc.size() != 0 || crc_out !== 8'h07) begin
         n_fail++;
         $display("FAIL stall_crc: got crc=%h pending=%0d expected 07 pending=0",
                  crc_out, exp_words.size() + exp_crc.size());
      end
   endtask

   task automatic test_ignore_new_data();
      m_ready = 1'b0;
      send(8'h3C, 8'hC3, 1'b1);
      new_data = 1'b1;
      data_a   = 8'hFF;
      data_b   = 8'hEE;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b0 || m_data !== 8'h3C) begin
         n_fail++;
         $display("FAIL ignore_busy: got in_ready=%b data=%h expected 0 3c", in_ready, m_data);
      end
      @(posedge clk); #1;
      new_data = 1'b0;
      m_ready  = 1'b1;
      for (int i = 0; i < 50 && (exp_words.size() != 0 || exp_crc.size() != 0); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      n_tests++;
      if (exp_words.size() != 0 || exp_crc.size() != 0 || crc_out !== model_crc(8'h3C, 8'hC3) || m_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_crc: got crc=%h m_valid=%b pending=%0d expected %h 0 0",
                  crc_out, m_valid, exp_words.size() + exp_crc.size(), model_crc(8'h3C, 8'hC3));
      end
   endtask

   task automatic test_flush();
      int sb, sc;
      m_ready = 1'b1;
      sb = seen_b; sc = seen_c;
      send(8'h11, 8'h22, 1'b0);
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (in_ready !== 1'b1 || m_valid !== 1'b0 || push_b_done !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle: got rdy=%b v=%b pb=%b expected 1 0 0", in_ready, m_valid, push_b_done);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_tests++;
         if (crc_out !== last_crc) begin
            n_fail++;
            $display("FAIL flush_crc_hold: got %h expected %h", crc_out, last_crc);
         end
      end
      n_tests++;
      if (seen_b != sb || seen_c != sc || exp_words.size() != 0) begin
         n_fail++;
         $display("FAIL flush_pulses: got pb=%0d crcv=%0d pending=%0d expected 0 0 0",
                  seen_b - sb, seen_c - sc, exp_words.size());
      end
   endtask

   task automatic test_back_to_back();
      int         caps;
      int         cyc;
      int         last_cyc;
      logic [7:0] a, b;
      caps     = 0;
      cyc      = 0;
      last_cyc = -1;
      m_ready  = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         cyc++;
         if (in_ready === 1'b1) begin
            if (caps == 6) begin
               new_data = 1'b0;
               break;
            end
            if (last_cyc >= 0) begin
               n_tests++;
               if (cyc - last_cyc != 4) begin
                  n_fail++;
                  $display("FAIL b2b_spacing: got %0d cycles expected 4", cyc - last_cyc);
               end
            end
            a = 8'($urandom);
            b = 8'($urandom);
            new_data = 1'b1;
            data_a   = a;
            data_b   = b;
            exp_words.push_back(a);
            exp_words.push_back(b);
            exp_crc.push_back(model_crc(a, b));
            last_crc = model_crc(a, b);
            last_cyc = cyc;
            caps++;
         end
      end
      new_data = 1'b0;
      for (int i = 0; i < 50 && (exp_words.size() != 0 || exp_crc.size() != 0); i++) @(negedge clk);
      n_tests++;
      if (caps != 6 || exp_words.size() != 0 || exp_crc.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: got caps=%0d pending=%0d expected 6 0", caps, exp_words.size() + exp_crc.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_ignore_new_data();
      test_flush();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
